// File: rtl/wishbone_bus_if.sv
// wishbone_bus_if
//   Adapter between one CPU-side memory port and a Wishbone B3 classic master.
//   A single-cycle ce/we/sel/addr request becomes a registered Wishbone
//   transfer. The pipeline is held with stallreq until the slave acks, the
//   transfer times out, or a flush aborts it.
// Parameters
//   STALL_BIT   : index of stall[5:0] that freezes the requesting stage
//   TIMEOUT_CYC : BUSY cycles without ack before abort (1..255)
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   stall, flush       : pipeline control from ctrl
//   cpu_ce_i .. sel_i  : CPU request
//   cpu_data_o         : read data to CPU
//   stallreq           : pipeline stall request
//   bus_err_o          : one-cycle pulse after a timeout abort
//   wishbone_*         : Wishbone classic master signals (outputs registered)
module wishbone_bus_if #(
  parameter int STALL_BIT   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_err_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_FOR_STALL
  } state_t;

  // Counter value seen in the last BUSY cycle before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] rd_buf;
  logic [7:0]  cnt;
  logic        timeout;
  logic        stall_me;
  logic        stall_unused;

  assign stall_me     = stall[STALL_BIT];
  assign stall_unused = ^stall;
  assign timeout      = (cnt == CNT_LAST) && !wishbone_ack_i;

  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    cpu_data_o = '0;
    case (state)
      IDLE: begin
        stallreq = cpu_ce_i && !flush;
        if (cpu_ce_i && !flush) state_next = BUSY;
      end
      BUSY: begin
        if (flush) begin
          state_next = IDLE;
        end else if (wishbone_ack_i) begin
          state_next = stall_me ? WAIT_FOR_STALL : IDLE;
          if (!wishbone_we_o) cpu_data_o = wishbone_data_i;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          stallreq = 1'b1;
        end
      end
      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf;
        if (!stall_me || flush) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      stallreq   = 1'b0;
      cpu_data_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_buf          <= '0;
      cnt             <= '0;
      bus_err_o       <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= '0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else begin
      state     <= state_next;
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush) begin
            wishbone_addr_o <= cpu_addr_i;
            wishbone_data_o <= cpu_data_i;
            wishbone_we_o   <= cpu_we_i;
            wishbone_sel_o  <= cpu_sel_i;
            wishbone_stb_o  <= 1'b1;
            wishbone_cyc_o  <= 1'b1;
            cnt             <= '0;
          end
        end
        BUSY: begin
          // Flush, ack and timeout all end the transfer; only the side
          // effects differ (flush priority first, then ack, then timeout).
          if (flush || wishbone_ack_i || timeout) begin
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
          end
          if (flush) begin
            rd_buf <= '0;
          end else if (wishbone_ack_i) begin
            if (!wishbone_we_o) rd_buf <= wishbone_data_i;
          end else if (timeout) begin
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Testbench for wishbone_bus_if: directed scenarios followed by random
// traffic, compared against a transaction-level model through a scoreboard.
module tb_wishbone_bus_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_err_o;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;

  wishbone_bus_if #(.STALL_BIT(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .bus_err_o(bus_err_o),
    .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
    .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
    .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
    .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        stallreq;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: an outstanding request plus the held read result.
  bit          in_flight = 0;
  bit          holding   = 0;
  int          waited    = 0;
  bit          err_next  = 0;
  logic [31:0] rd_buf    = '0;
  logic [31:0] r_addr    = '0;
  logic [31:0] r_data    = '0;
  logic        r_we      = 1'b0;
  logic [3:0]  r_sel     = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit ce, input logic [31:0] a, input logic [31:0] d,
                       input bit we, input logic [3:0] sel, input bit fl,
                       input logic [5:0] st, input bit ack, input logic [31:0] wd);
    exp_t e;
    bit   done_to;
    @(posedge clk);
    #1;
    rst = r; cpu_ce_i = ce; cpu_addr_i = a; cpu_data_i = d; cpu_we_i = we;
    cpu_sel_i = sel; flush = fl; stall = st; wishbone_ack_i = ack; wishbone_data_i = wd;

    done_to   = in_flight && !fl && !ack && (waited + 1 == TO);
    e.addr    = in_flight ? r_addr : '0;
    e.wdata   = in_flight ? r_data : '0;
    e.we      = in_flight ? r_we : 1'b0;
    e.sel     = in_flight ? r_sel : '0;
    e.stb     = in_flight;
    e.err     = err_next;
    e.data    = '0;
    e.stallreq = 1'b0;
    if (!r) begin
      if (in_flight) begin
        e.stallreq = !(fl || ack || done_to);
        if (!fl && ack && !r_we) e.data = wd;
      end else if (holding) begin
        e.data = rd_buf;
      end else begin
        e.stallreq = ce && !fl;
      end
    end
    exp_q.push_back(e);

    err_next = 0;
    if (r) begin
      in_flight = 0; holding = 0; waited = 0; rd_buf = '0;
    end else if (in_flight) begin
      if (fl) begin
        in_flight = 0; rd_buf = '0;
      end else if (ack) begin
        in_flight = 0;
        if (!r_we) rd_buf = wd;
        holding = st[4];
      end else if (done_to) begin
        in_flight = 0; err_next = 1;
      end else begin
        waited++;
      end
    end else if (holding) begin
      if (!st[4] || fl) holding = 0;
    end else if (ce && !fl) begin
      in_flight = 1; waited = 0;
      r_addr = a; r_data = d; r_we = we; r_sel = sel;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_data_o", cpu_data_o, e.data);
        chk("stallreq", 32'(stallreq), 32'(e.stallreq));
        chk("bus_err_o", 32'(bus_err_o), 32'(e.err));
        chk("wb_addr", wishbone_addr_o, e.addr);
        chk("wb_data", wishbone_data_o, e.wdata);
        chk("wb_we", 32'(wishbone_we_o), 32'(e.we));
        chk("wb_sel", 32'(wishbone_sel_o), 32'(e.sel));
        chk("wb_stb", 32'(wishbone_stb_o), 32'(e.stb));
        chk("wb_cyc", 32'(wishbone_cyc_o), 32'(e.stb));
      end
    end
  end

  initial begin
    // reset
    cycle(1, 0, '0, '0, 0, '0, 0, '0, 0, '0);
    cycle(1, 1, 32'h4, '0, 0, 4'hf, 0, '0, 1, 32'h1);
    idle(1);
    // read, three wait cycles, then ack with data
    cycle(0, 1, 32'h100, '0, 0, 4'hf, 0, '0, 0, '0);
    repeat (3) cycle(0, 0, '0, '0, 0, '0, 0, '0, 0, 32'h1111);
    cycle(0, 0, '0, '0, 0, '0, 0, '0, 1, 32'hDEADBEEF);
    idle(1);
    // write acked next cycle
    cycle(0, 1, 32'h20, 32'h12345678, 1, 4'b0011, 0, '0, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, 0, '0, 1, 32'h5555);
    idle(1);
    // read acked while stall[4] held for two more cycles
    cycle(0, 1, 32'h40, '0, 0, 4'hf, 0, 6'h10, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, 0, 6'h10, 1, 32'hA5A5A5A5);
    repeat (2) cycle(0, 0, '0, '0, 0, '0, 0, 6'h10, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, 0, 6'h00, 0, '0);
    idle(1);
    // flush coinciding with ack
    cycle(0, 1, 32'h80, '0, 0, 4'hf, 0, 6'h10, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, 1, 6'h10, 1, 32'hCAFEF00D);
    idle(2);
    // timeout with no ack
    cycle(0, 1, 32'hC0, '0, 0, 4'h1, 0, '0, 0, '0);
    idle(TO + 2);
    // reset during BUSY, late ack ignored
    cycle(0, 1, 32'hE0, '0, 0, 4'hf, 0, '0, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, 0, '0, 0, '0);
    cycle(1, 0, '0, '0, 0, '0, 0, '0, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, 0, '0, 1, 32'h77777777);
    idle(1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), $urandom, $urandom,
            ($urandom_range(0, 1) == 1), 4'($urandom), ($urandom_range(0, 9) == 0),
            6'($urandom), ($urandom_range(0, 3) == 0), $urandom);
    end
    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
